// File: rtl/mem_sync_arbiter.sv
// Round-robin row-sync arbiter: one bank at a time, sync pulse then wait for ready or timeout.
// Latency: req to sync 2 cycles, 5 cycles minimum per grant; no backpressure, requests accumulate in pending.
module mem_sync_arbiter #(
    parameter  int BGWIDTH = 2,
    parameter  int BAWIDTH = 2,
    parameter  int TIMEOUT = 64,
    localparam int BIDW    = BGWIDTH + BAWIDTH,
    localparam int NBANKS  = 2 ** BIDW
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [NBANKS-1:0] req_i,
    input  logic [NBANKS-1:0] ready_i,
    input  logic              err_clr_i,
    output logic [NBANKS-1:0] sync_o,
    output logic              stall_o,
    output logic              grant_valid_o,
    output logic [BIDW-1:0]   grant_id_o,
    output logic [BIDW:0]     pending_cnt_o,
    output logic              err_timeout_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NBANKS-1:0] pending_q, pending_d;
    logic [BIDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BIDW-1:0]   grant_id_q, grant_id_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic [NBANKS-1:0] clr_mask;
    logic              timeout_hit;
    logic              pick_vld;
    logic [BIDW-1:0]   pick_id;
    logic [BIDW-1:0]   scan_idx;
    logic [BIDW:0]     pop_cnt;

    // Scan from the highest offset down so the bank closest to rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = NBANKS - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + BIDW'(k);
            if (pending_q[scan_idx]) begin
                pick_vld = 1'b1;
                pick_id  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        clr_mask    = '0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_id;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_i[grant_id_q]) begin
                    state_d = ST_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                clr_mask = NBANKS'(1) << grant_id_q;
                rr_ptr_d = grant_id_q + BIDW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A request arriving in the clearing cycle must survive, so req is OR-ed after the clear.
    assign pending_d = (pending_q & ~clr_mask) | req_i;
    assign err_d     = timeout_hit | (err_q & ~err_clr_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NBANKS; i++) begin
            pop_cnt = pop_cnt + (BIDW + 1)'(pending_q[i]);
        end
    end

    assign sync_o        = (state_q == ST_ISSUE) ? (NBANKS'(1) << grant_id_q) : '0;
    assign stall_o       = (state_q != ST_IDLE) | (|pending_q);
    assign grant_valid_o = (state_q != ST_IDLE);
    assign grant_id_o    = grant_id_q;
    assign pending_cnt_o = pop_cnt;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Bench for mem_sync_arbiter: vector tables, directed corner sequences, randomized run against a model.
module tb_mem_sync_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic [15:0] ready;
    logic        err_clr;
    logic [15:0] sync;
    logic        stall;
    logic        grant_valid;
    logic [3:0]  grant_id;
    logic [4:0]  pending_cnt;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    mem_sync_arbiter #(
        .BGWIDTH(2),
        .BAWIDTH(2),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_i        (req),
        .ready_i      (ready),
        .err_clr_i    (err_clr),
        .sync_o       (sync),
        .stall_o      (stall),
        .grant_valid_o(grant_valid),
        .grant_id_o   (grant_id),
        .pending_cnt_o(pending_cnt),
        .err_timeout_o(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [15:0] req;
        logic [15:0] rdy;
        logic        clr;
        logic [15:0] e_sync;
        logic        e_stall;
        logic [4:0]  e_cnt;
        logic        e_gv;
        logic [3:0]  e_gid;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rn, input logic [15:0] rq, input logic [15:0] rd,
                       input logic [15:0] es, input logic est, input logic [4:0] ec,
                       input logic egv, input logic [3:0] eg);
        vec_t v;
        v.rst_n = rn; v.req = rq; v.rdy = rd; v.clr = 1'b0;
        v.e_sync = es; v.e_stall = est; v.e_cnt = ec; v.e_gv = egv; v.e_gid = eg; v.e_err = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Inputs for cycle n are applied just after edge n; outputs are settled by then.
    task automatic drive(input logic rn, input logic [15:0] rq, input logic [15:0] rd, input logic cl);
        @(posedge clk);
        #1;
        reset_n = rn; req = rq; ready = rd; err_clr = cl;
        #1;
    endtask

    function automatic logic [27:0] outs();
        return {sync, stall, pending_cnt, grant_valid, grant_id, err_timeout};
    endfunction

    // Reference model: a grant is a transaction aged from its sync cycle (age 0).
    bit [15:0] m_pend;
    bit        m_busy;
    bit        m_done;
    int        m_age;
    int        m_ptr;
    int        m_gid;
    bit        m_err;

    function automatic void m_reset();
        m_pend = '0; m_busy = 0; m_done = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_err = 0;
    endfunction

    function automatic logic [27:0] m_expect();
        logic [15:0] s;
        s = (m_busy && m_age == 0) ? (16'h1 << m_gid) : 16'h0;
        return {s, m_busy || (m_pend != 0), 5'($countones(m_pend)), m_busy, 4'(m_gid), m_err};
    endfunction

    function automatic void m_step(input logic [15:0] rq, input logic [15:0] rd, input logic cl);
        bit [15:0] p;
        bit        to;
        bit        found;
        p = m_pend;
        to = 0;
        found = 0;
        if (!m_busy) begin
            for (int k = 0; k < 16; k++) begin
                if (!found && m_pend[(m_ptr + k) % 16]) begin
                    found = 1;
                    m_gid = (m_ptr + k) % 16;
                end
            end
            if (found) begin
                m_busy = 1; m_age = 0; m_done = 0;
            end
        end else if (m_done) begin
            p[m_gid] = 1'b0;
            m_ptr = (m_gid + 1) % 16;
            m_busy = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rd[m_gid]) begin
            m_done = 1;
        end else if (m_age == TIMEOUT) begin
            to = 1; m_done = 1;
        end else begin
            m_age++;
        end
        m_pend = p | rq;
        if (to) m_err = 1;
        else if (cl) m_err = 0;
    endfunction

    initial begin
        logic [27:0] exp_o;
        logic [15:0] rq;
        logic [15:0] rd;
        logic        rn;
        logic        cl;
        reset_n = 1'b0; req = '0; ready = '0; err_clr = 1'b0;

        // Single request to bank 5, ready from cycle 3.
        add(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0020, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0);
        add(1, 16'h0000, 16'h0000, 16'h0020, 1, 1, 1, 5);
        add(1, 16'h0000, 16'h0020, 16'h0000, 1, 1, 1, 5);
        add(1, 16'h0000, 16'h0020, 16'h0000, 1, 1, 1, 5);
        add(1, 16'h0000, 16'h0020, 16'h0000, 0, 0, 0, 5);
        add(1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 5);
        // Banks 3 and 9 together from rr_ptr=0, ready always high.
        add(0, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0208, 16'hFFFF, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 2, 0, 0);
        add(1, 16'h0000, 16'hFFFF, 16'h0008, 1, 2, 1, 3);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 2, 1, 3);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 2, 1, 3);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0, 3);
        add(1, 16'h0000, 16'hFFFF, 16'h0200, 1, 1, 1, 9);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 1, 9);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 1, 9);
        add(1, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0, 9);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].e_sync, vecs[i].e_stall, vecs[i].e_cnt, vecs[i].e_gv,
                     vecs[i].e_gid, vecs[i].e_err}));
        end

        // Timeout on bank 2 followed by err_clr.
        drive(0, 16'h0, 16'h0, 0);
        for (int c = 0; c <= 69; c++) begin
            drive(1, (c == 0) ? 16'h0004 : 16'h0000, 16'h0000, c == 68);
            if (c == 2)  chk("to_sync", 32'(sync), 32'h0004);
            if (c == 66) chk("to_wait_end", 32'({err_timeout, grant_valid}), 32'b01);
            if (c == 67) chk("to_done", 32'({err_timeout, grant_valid}), 32'b11);
            if (c == 68) chk("to_idle", 32'({err_timeout, grant_valid, stall, pending_cnt}), 32'({3'b100, 5'd0}));
            if (c == 69) chk("to_errclr", 32'(err_timeout), 32'h0);
        end

        // Re-request held through the DONE cycle of bank 7.
        drive(0, 16'h0, 16'h0, 0);
        for (int c = 0; c <= 9; c++) begin
            drive(1, (c <= 4) ? 16'h0080 : 16'h0000, (c >= 3) ? 16'h0080 : 16'h0000, 0);
            if (c == 2) chk("rr_sync1", 32'(sync), 32'h0080);
            if (c == 5) chk("rr_keep", 32'({pending_cnt, grant_valid, stall}), 32'({5'd1, 2'b01}));
            if (c == 6) chk("rr_regrant", 32'({sync, grant_id}), 32'({16'h0080, 4'd7}));
            if (c == 9) chk("rr_clear", 32'({pending_cnt, stall}), 32'({5'd0, 1'b0}));
        end

        // Round-robin wrap: after bank 15, bank 0 goes first.
        drive(0, 16'h0, 16'h0, 0);
        for (int c = 0; c <= 13; c++) begin
            drive(1, (c == 0) ? 16'h8000 : ((c == 4) ? 16'h8001 : 16'h0000), 16'hFFFF, 0);
            if (c == 2)  chk("wrap_first", 32'(sync), 32'h8000);
            if (c == 5)  chk("wrap_cnt", 32'(pending_cnt), 32'd2);
            if (c == 6)  chk("wrap_b0", 32'({sync, grant_id}), 32'({16'h0001, 4'd0}));
            if (c == 10) chk("wrap_b15", 32'({sync, grant_id}), 32'({16'h8000, 4'd15}));
            if (c == 13) chk("wrap_empty", 32'({pending_cnt, stall}), 32'h0);
        end

        // Reset asserted mid-WAIT with banks 1 and 8 pending.
        drive(0, 16'h0, 16'h0, 0);
        for (int c = 0; c <= 20; c++) begin
            drive(c != 4, (c == 0) ? 16'h0102 : 16'h0000, (c >= 5) ? 16'hFFFF : 16'h0000, 0);
            if (c == 3) chk("rst_prewait", 32'({pending_cnt, grant_valid, grant_id}), 32'({5'd2, 1'b1, 4'd1}));
            if (c == 4) chk("rst_abort", 32'(outs()), 32'h0);
            if (c >= 5) chk($sformatf("rst_quiet%0d", c), 32'({sync, stall}), 32'h0);
        end

        // Randomized traffic against the model, with ready-starved windows to force timeouts.
        drive(0, 16'h0, 16'h0, 0);
        m_reset();
        for (int n = 0; n < 4000; n++) begin
            rn = ($urandom_range(0, 599) != 0);
            rq = '0;
            if ($urandom_range(0, 5) == 0) rq = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 19) == 0) rq = rq | (16'h1 << $urandom_range(0, 15));
            rd = (((n / 400) % 3) == 2) ? 16'h0000 : 16'($urandom & $urandom);
            cl = ($urandom_range(0, 15) == 0);
            drive(rn, rq, rd, cl);
            if (!rn) m_reset();
            exp_o = m_expect();
            chk($sformatf("rand%0d", n), 32'(outs()), 32'(exp_o));
            if (rn) m_step(rq, rd, cl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sync_arbiter.md
Name: mem_sync_arbiter

Overview:
- Sits directly upstream of the per-bank row-cache sync array and drives its per-bank sync inputs.
- Collects row-sync requests from all banks and services them one bank at a time in round-robin order.
- For each request: pulses sync to the chosen bank, waits for that bank's ready, then clears the request.
- Raises stall to the command path while any sync is pending or in flight; detects banks that never return ready.

Parameters:
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank address width.
- TIMEOUT, 64, maximum WAIT cycles before abandoning a grant.
- NBANKS (local), 2**(BGWIDTH+BAWIDTH), total banks; flat index = bg*2**BAWIDTH + ba.
- BIDW (local), BGWIDTH+BAWIDTH, bank index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NBANKS  per-bank sync request, level-sampled every cycle.
- ready  in  NBANKS  per-bank ready from the sync array.
- err_clr  in  1  clears err_timeout.
- sync  out  NBANKS  one-hot sync pulse to the granted bank.
- stall  out  1  hold-off to the command path.
- grant_valid  out  1  high while a grant is active (ISSUE/WAIT/DONE).
- grant_id  out  BIDW  currently granted flat bank index.
- pending_cnt  out  BIDW+1  popcount of the pending register.
- err_timeout  out  1  sticky flag: a WAIT expired without ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending=0; rr_ptr=0; wait_cnt=0.
  - sync=0; stall=0; grant_valid=0; grant_id=0; pending_cnt=0; err_timeout=0.
- Pending register:
  - Each edge: pending <= (pending & ~clr_mask) | req.
  - clr_mask is one-hot at grant_id only in DONE; otherwise 0.
  - If req[i] is high in the same cycle bank i is cleared, req wins and the bit stays set (re-request is never lost).
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if pending!=0, grant_id <= first set bit scanning rr_ptr, rr_ptr+1, ... modulo NBANKS; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: sync[grant_id]=1 for exactly this one cycle; wait_cnt <= 0; go to WAIT.
  - WAIT: sample ready[grant_id].
    - If ready is 1, go to DONE.
    - Else if wait_cnt == TIMEOUT-1, set err_timeout and go to DONE.
    - Else wait_cnt increments.
    - ready is ignored in ISSUE and for non-granted banks.
  - DONE: clear pending[grant_id] (subject to the req rule above); rr_ptr <= grant_id+1 wrapping to 0 after NBANKS-1; go to IDLE.
- Latency:
  - req high in cycle 0 gives pending in cycle 1 and sync in cycle 2.
  - ready high in cycle 3 gives DONE in cycle 4; IDLE and the cleared pending bit appear in cycle 5.
  - Minimum 5 cycles per grant; back-to-back grants start 4 cycles apart.
- Output definitions:
  - stall = (state!=IDLE) | (pending!=0), registered-state based with no combinational path from req.
  - sync is driven from state/grant_id only and is all-zero outside ISSUE.
  - pending_cnt reflects the registered pending value.
- err_timeout: set by a WAIT expiry; cleared by err_clr. If both occur in the same cycle, set wins.
- The current grant is never pre-empted; new requests only accumulate in pending.
- Reset asserted mid-operation aborts immediately and returns everything to the reset values, including clearing pending.

Test Plan:
- Single request: req[5] pulsed in cycle 0, ready[5]=1 from cycle 3 -> sync=16'h0020 in cycle 2 only; grant_id=5; stall high cycles 1–4, low cycle 5; pending_cnt 1→0.
- Simultaneous requests: req[3] and req[9] pulsed together with rr_ptr=0, ready always 1 -> sync to bank 3 in cycle 2, bank 9 in cycle 6; pending_cnt 2,2,2,2,1,...,0.
- Round-robin wrap: after servicing bank 15 (rr_ptr=0), req[15] and req[0] both pending -> bank 0 granted before bank 15.
- Timeout: req[2], ready held 0 with TIMEOUT=64 -> DONE exactly 64 cycles after entering WAIT; err_timeout=1; pending[2] cleared. Then err_clr=1 -> err_timeout=0 next cycle.
- Re-request: req[7] held high through its DONE cycle -> pending[7] stays 1 and bank 7 is re-granted in the next IDLE.
- Reset mid-WAIT: reset_n low while in WAIT with pending=16'h0102 -> sync=0, stall=0, pending_cnt=0, state IDLE immediately; no sync after release until a new req.
